ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage MIPS pipeline, directly downstream of ID. Holds the ID/EX pipeline register,
//  performs the 12-op ALU, issues data SRAM requests, and owns HI/LO plus a 32-iteration radix-2 divider
//  (div/divu) that stalls the pipe. Produces ex_to_mem_bus, which MEM consumes and ID reads for forwarding.
// PARAMETERS (from lib/defines.vh, not overridable)
//  `ID_TO_EX_WD   159  ID/EX bus width
//  `EX_TO_MEM_WD  76   EX/MEM bus width
//  `StallBus      6    stall vector width; `Stop=1, `NoStop=0
// PORTS
//  clk              in   1    clock; all state updates on posedge
//  rst              in   1    asynchronous, active-low reset
//  stall            in   6    pipeline stall vector; bit2 = EX, bit3 = MEM
//  stallreq_for_ex  out  1    divider busy; control unit stops stages 0..2
//  id_to_ex_bus     in   159  {pc[158:127],inst[126:95],alu_op[94:83],src1[82:80],src2[79:76],ram_en[75],ram_wen[74:71],rf_we[70],rf_waddr[69:65],sel_rf_res[64],rs_data[63:32],rt_data[31:0]}
//  ex_to_mem_bus    out  76   {pc[75:44],ram_en[43],ram_wen[42:39],sel_rf_res[38],rf_we[37],rf_waddr[36:32],ex_result[31:0]}
//  data_sram_en     out  1    data SRAM enable
//  data_sram_wen    out  4    byte write enables
//  data_sram_addr   out  32   byte address = ex_result
//  data_sram_wdata  out  32   store data = rt_data
// BEHAVIOUR
//  Reset (rst=0, async): ID/EX reg, HI, LO <= 0; FSM <= IDLE. All outputs 0 (empty reg => bubble, stallreq=0).
//  ID/EX reg: stall[2]=Stop & stall[3]=NoStop -> load all-zero bubble; else stall[2]=NoStop -> load id_to_ex_bus;
//   else hold. An all-zero entry has rf_we=0, ram_en=0 and causes no side effect.
//  ALU operands: src1 one-hot {sa zext, pc, rs}; src2 one-hot {imm zext, 32'd8, imm sext, rt}; none set -> 0.
//  alu_op MSB..LSB = add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui. add/sub wrap mod 2^32, no overflow trap.
//   slt signed, sltu unsigned, result 0/1. Shifts: src2 shifted by src1[4:0]. lui: {src2[15:0],16'h0}.
//  Extra decode from inst (opcode 0): func 011010 div, 011011 divu, 010000 mfhi, 010010 mflo.
//   mfhi/mflo override rf_we=1, rf_waddr=rd, ex_result=HI/LO. Otherwise ex_result=ALU result; all others pass through.
//  Memory: data_sram_en=ram_en, wen=ram_wen, addr=ex_result, wdata=rt_data, combinational from the ID/EX reg.
//   Requests repeat while EX is held; repeats are identical and idempotent.
//  Divider FSM (IDLE, BUSY, DONE):
//   IDLE: div/divu in reg -> latch |rs|,|rt| (signed) or raw (divu), signs, count=0; -> BUSY. stallreq=1.
//   BUSY: one restoring shift-subtract step per cycle; after 32 steps -> DONE and write HI=rem, LO=quot once,
//    on that same edge. stallreq=1 throughout. Total stallreq = 33 cycles per div.
//   DONE: stallreq=0. Stay in DONE while stall[2]=Stop (no restart, no rewrite); -> IDLE on the edge EX reg loads.
//   Signed fixup: quot negated if signs differ; rem takes dividend sign. 0x80000000 / -1 -> LO=0x80000000, HI=0.
//   Divide by zero: same latency; HI=rs_data, LO=32'hFFFF_FFFF, for both div and divu.
//  mfhi/mflo directly after div read the new HI/LO; the div stall guarantees ordering, so no bypass is needed.
//  rst mid-divide: FSM->IDLE, HI/LO=0, stallreq drops at once; the partial result is discarded.
// TESTING
//  addiu rs=5, imm=0xFFFF -> ex_to_mem_bus[31:0]=4, [37]=1, [36:32]=rt.
//  slt rs=0xFFFFFFFF rt=1 -> result 1; sltu same operands -> 0; sra rt=0x80000000 sa=4 -> 0xF8000000.
//  sw base=0x100 imm=8 rt=0xDEADBEEF -> data_sram_en=1, wen=4'hF, addr=0x108, wdata=0xDEADBEEF, [37]=0.
//  div rs=-7 rt=2 -> stallreq high exactly 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFD; next mflo returns LO.
//  divu rs=9 rt=0 -> HI=9, LO=0xFFFFFFFF; div held in DONE by stall[3]=Stop for 3 cycles -> HI/LO written once.
//  stall[2]=Stop, stall[3]=NoStop -> bubble (ex_to_mem_bus=0); rst low during BUSY -> stallreq=0, HI=LO=0.

Source files
------------

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX -> EX/MEM boundary of the execute stage.
//
// Flow control between the stages is a stall vector rather than a
// valid/ready pair: the control unit drives stall (bit2 = EX, bit3 = MEM).
// When stall[2] is Stop, the EX stage holds its ID/EX register. If MEM
// keeps moving at the same time (stall[3] = NoStop), a bubble is loaded
// instead. The EX stage raises stallreq_for_ex while the divider owns the
// pipe. stallreq_for_ex is a function of EX state only, never of stall, so
// it may be fed back combinationally into the stall vector.
//
// Signals
//   stall            control -> EX   6-bit stall vector
//   stallreq_for_ex  EX -> control   divider busy
//   id_to_ex_bus     ID -> EX        159-bit decoded instruction bundle
//   ex_to_mem_bus    EX -> MEM/ID    76-bit result bundle (also ID forwarding)
//   data_sram_*      EX -> SRAM      data memory request
//   div_state        EX -> debug     divider FSM state (0 idle, 1 busy, 2 done)
interface ex_stage_if;
  logic [5:0]   stall;
  logic         stallreq_for_ex;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic [1:0]   div_state;

  modport master (
    input  stall,
    input  id_to_ex_bus,
    output stallreq_for_ex,
    output ex_to_mem_bus,
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    output div_state
  );

  modport slave (
    output stall,
    output id_to_ex_bus,
    input  stallreq_for_ex,
    input  ex_to_mem_bus,
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    input  div_state
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Holds the ID/EX register, runs the 12-op ALU, issues data SRAM requests,
// and owns HI/LO together with a 32-step restoring divider (div/divu) that
// stalls the front of the pipe while it runs.
//
// Ports
//   clk  in   clock, all state changes on posedge
//   rst  in   asynchronous active-low reset
//   bus  ex_stage_if.master  stall vector, ID/EX bus in; EX/MEM bus,
//        data SRAM request, stallreq_for_ex and divider state out
module ex_stage (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.master bus
);

  localparam logic STOP = 1'b1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // ---------------------------------------------------------------- ID/EX reg
  logic [158:0] id_ex_q;
  logic         ex_hold;
  logic         ex_bubble;

  assign ex_hold   = (bus.stall[2] == STOP);
  assign ex_bubble = ex_hold && (bus.stall[3] != STOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_q <= '0;
    end else if (ex_bubble) begin
      id_ex_q <= '0;
    end else if (!ex_hold) begin
      id_ex_q <= bus.id_to_ex_bus;
    end
  end

  logic [31:0] pc;
  logic [31:0] inst;
  logic [11:0] alu_op;
  logic [2:0]  src1_sel;
  logic [3:0]  src2_sel;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        sel_rf_res;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  assign pc         = id_ex_q[158:127];
  assign inst       = id_ex_q[126:95];
  assign alu_op     = id_ex_q[94:83];
  assign src1_sel   = id_ex_q[82:80];
  assign src2_sel   = id_ex_q[79:76];
  assign ram_en     = id_ex_q[75];
  assign ram_wen    = id_ex_q[74:71];
  assign rf_we      = id_ex_q[70];
  assign rf_waddr   = id_ex_q[69:65];
  assign sel_rf_res = id_ex_q[64];
  assign rs_data    = id_ex_q[63:32];
  assign rt_data    = id_ex_q[31:0];

  logic [15:0] imm;
  logic [4:0]  sa;
  logic [4:0]  rd;
  logic [5:0]  func;
  logic        is_special;
  logic        is_div;
  logic        is_divu;
  logic        is_mfhi;
  logic        is_mflo;

  assign imm        = inst[15:0];
  assign sa         = inst[10:6];
  assign rd         = inst[15:11];
  assign func       = inst[5:0];
  assign is_special = (inst[31:26] == 6'b000000);
  assign is_div     = is_special && (func == 6'b011010);
  assign is_divu    = is_special && (func == 6'b011011);
  assign is_mfhi    = is_special && (func == 6'b010000);
  assign is_mflo    = is_special && (func == 6'b010010);

  // ---------------------------------------------------------------- ALU
  // Operand selects are one-hot; AND-OR muxing yields 0 when none is set.
  logic [31:0] src1_val;
  logic [31:0] src2_val;
  logic [31:0] alu_res;

  always_comb begin
    src1_val = ({32{src1_sel[2]}} & {27'b0, sa})
             | ({32{src1_sel[1]}} & pc)
             | ({32{src1_sel[0]}} & rs_data);
    src2_val = ({32{src2_sel[3]}} & {16'b0, imm})
             | ({32{src2_sel[2]}} & 32'd8)
             | ({32{src2_sel[1]}} & {{16{imm[15]}}, imm})
             | ({32{src2_sel[0]}} & rt_data);
  end

  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] slt_res;
  logic [31:0] sltu_res;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;
  logic [31:0] lui_res;

  assign add_res  = src1_val + src2_val;
  assign sub_res  = src1_val - src2_val;
  assign slt_res  = {31'b0, ($signed(src1_val) < $signed(src2_val))};
  assign sltu_res = {31'b0, (src1_val < src2_val)};
  assign sll_res  = src2_val << src1_val[4:0];
  assign srl_res  = src2_val >> src1_val[4:0];
  assign sra_res  = $signed(src2_val) >>> src1_val[4:0];
  assign lui_res  = {src2_val[15:0], 16'h0000};

  always_comb begin
    alu_res = ({32{alu_op[11]}} & add_res)
            | ({32{alu_op[10]}} & sub_res)
            | ({32{alu_op[9]}}  & slt_res)
            | ({32{alu_op[8]}}  & sltu_res)
            | ({32{alu_op[7]}}  & (src1_val & src2_val))
            | ({32{alu_op[6]}}  & ~(src1_val | src2_val))
            | ({32{alu_op[5]}}  & (src1_val | src2_val))
            | ({32{alu_op[4]}}  & (src1_val ^ src2_val))
            | ({32{alu_op[3]}}  & sll_res)
            | ({32{alu_op[2]}}  & srl_res)
            | ({32{alu_op[1]}}  & sra_res)
            | ({32{alu_op[0]}}  & lui_res);
  end

  // ---------------------------------------------------------------- divider
  div_state_t  state_q;
  logic [4:0]  count_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvsr_q;
  logic [31:0] rs_raw_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        dbz_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // Magnitudes for the signed case; divu uses the raw operands.
  logic [31:0] rs_abs;
  logic [31:0] rt_abs;
  assign rs_abs = (is_div && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
  assign rt_abs = (is_div && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract when it fits. Bit 32 of the difference is the borrow.
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        take;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;

  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvsr_q};
    take   = ~diff[32];
    rem_nx = take ? diff[31:0] : rem_sh[31:0];
    quo_nx = {quo_q[30:0], take};
  end

  // Divide by zero bypasses the sign fixup entirely.
  logic [31:0] hi_final;
  logic [31:0] lo_final;
  assign hi_final = dbz_q ? rs_raw_q : (neg_rem_q ? (~rem_nx + 32'd1) : rem_nx);
  assign lo_final = dbz_q ? 32'hFFFF_FFFF : (neg_quo_q ? (~quo_nx + 32'd1) : quo_nx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_IDLE;
      count_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      rs_raw_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (is_div || is_divu) begin
            quo_q     <= rs_abs;
            rem_q     <= '0;
            dvsr_q    <= rt_abs;
            rs_raw_q  <= rs_data;
            neg_quo_q <= is_div && (rs_data[31] ^ rt_data[31]);
            neg_rem_q <= is_div && rs_data[31];
            dbz_q     <= (rt_data == 32'd0);
            count_q   <= '0;
            state_q   <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          quo_q   <= quo_nx;
          rem_q   <= rem_nx;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            hi_q    <= hi_final;
            lo_q    <= lo_final;
            state_q <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          // Leave only when EX accepts a new instruction, so a div still
          // sitting in a held EX register cannot restart.
          if (!ex_hold) begin
            state_q <= DIV_IDLE;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  // Combinational in IDLE so the front stages freeze in the very cycle the
  // div arrives; HI/LO ordering for a following mfhi/mflo relies on this.
  assign bus.stallreq_for_ex = ((state_q == DIV_IDLE) && (is_div || is_divu))
                             || (state_q == DIV_BUSY);
  assign bus.div_state = state_q;

  // ---------------------------------------------------------------- outputs
  logic [31:0] ex_result;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;

  assign ex_result  = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);
  assign rf_we_o    = rf_we || is_mfhi || is_mflo;
  assign rf_waddr_o = (is_mfhi || is_mflo) ? rd : rf_waddr;

  assign bus.ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we_o, rf_waddr_o, ex_result};
  assign bus.data_sram_en    = ram_en;
  assign bus.data_sram_wen   = ram_wen;
  assign bus.data_sram_addr  = ex_result;
  assign bus.data_sram_wdata = rt_data;

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], bus.stall[5:4], bus.stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_stage_if bus_if ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Control-unit model: divider busy freezes stages 0..2; stall_force adds
  // directed stalls on top.
  logic [5:0] stall_force;
  always_comb bus_if.stall = (bus_if.stallreq_for_ex ? 6'b000111 : 6'b000000) | stall_force;

  int total = 0;
  int bad   = 0;

  localparam logic [11:0] OP_NONE = 12'h000;
  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND  = 12'h080;
  localparam logic [11:0] OP_NOR  = 12'h040;
  localparam logic [11:0] OP_OR   = 12'h020;
  localparam logic [11:0] OP_XOR  = 12'h010;
  localparam logic [11:0] OP_SLL  = 12'h008;
  localparam logic [11:0] OP_SRL  = 12'h004;
  localparam logic [11:0] OP_SRA  = 12'h002;
  localparam logic [11:0] OP_LUI  = 12'h001;

  localparam logic [2:0] S1_NONE = 3'b000;
  localparam logic [2:0] S1_SA   = 3'b100;
  localparam logic [2:0] S1_PC   = 3'b010;
  localparam logic [2:0] S1_RS   = 3'b001;
  localparam logic [3:0] S2_ZX   = 4'b1000;
  localparam logic [3:0] S2_8    = 4'b0100;
  localparam logic [3:0] S2_SX   = 4'b0010;
  localparam logic [3:0] S2_RT   = 4'b0001;

  localparam logic [31:0] PC0 = 32'hBFC0_0000;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_BUSY = 2'd1;
  localparam logic [1:0]  ST_DONE = 2'd2;

  task automatic check_eq(input string tag, input logic [75:0] got, input logic [75:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [11:0] op, input logic [2:0] s1,
                                      input logic [3:0] s2, input logic ram_en,
                                      input logic [3:0] wen, input logic we,
                                      input logic [4:0] waddr, input logic sel,
                                      input logic [31:0] rs, input logic [31:0] rt);
    return {pc, inst, op, s1, s2, ram_en, wen, we, waddr, sel, rs, rt};
  endfunction

  function automatic logic [75:0] exp_bus(input logic [31:0] pc, input logic ram_en,
                                          input logic [3:0] wen, input logic sel,
                                          input logic we, input logic [4:0] waddr,
                                          input logic [31:0] res);
    return {pc, ram_en, wen, sel, we, waddr, res};
  endfunction

  function automatic logic [158:0] mk_mf(input logic hi, input logic [4:0] rd);
    logic [5:0] func;
    func = hi ? 6'b010000 : 6'b010010;
    return mk(PC0, {6'b0, 10'b0, rd, 5'b0, func}, OP_NONE, S1_NONE, 4'b0, 1'b0, 4'h0,
              1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
  endfunction

  // Present an instruction before a rising edge; returns 1 time unit after it.
  task automatic issue(input logic [158:0] b);
    @(negedge clk);
    bus_if.id_to_ex_bus = b;
    @(posedge clk);
    #1;
  endtask

  // Register-writing ALU op; rt field of inst is the destination.
  task automatic alu_vec(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] exp_res);
    issue(mk(pc, inst, op, s1, s2, 1'b0, 4'h0, 1'b1, inst[20:16], 1'b0, rs, rt));
    check_eq(tag, bus_if.ex_to_mem_bus, exp_bus(pc, 1'b0, 4'h0, 1'b0, 1'b1, inst[20:16], exp_res));
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int hold);
    int cyc;
    logic [5:0] func;
    cyc  = 0;
    func = sgn ? 6'b011010 : 6'b011011;
    issue(mk(PC0, {6'b0, 5'd4, 5'd5, 10'b0, func}, OP_NONE, S1_NONE, 4'b0, 1'b0, 4'h0,
             1'b0, 5'd0, 1'b0, rs, rt));
    while (bus_if.stallreq_for_ex && cyc < 200) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    check_eq($sformatf("%s_stall_cycles", tag), 76'(cyc), 76'd33);
    check_eq($sformatf("%s_state_done", tag), 76'(bus_if.div_state), 76'(ST_DONE));
    if (hold > 0) begin
      stall_force = 6'b001111;
      repeat (hold) @(posedge clk);
      #1;
      check_eq($sformatf("%s_hold_state", tag), 76'(bus_if.div_state), 76'(ST_DONE));
      check_eq($sformatf("%s_hold_no_restart", tag), 76'(bus_if.stallreq_for_ex), 76'd0);
      stall_force = 6'b000000;
    end
    issue(mk_mf(1'b0, 5'd12));
    check_eq($sformatf("%s_mflo", tag), bus_if.ex_to_mem_bus,
             exp_bus(PC0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd12, exp_lo));
    issue(mk_mf(1'b1, 5'd13));
    check_eq($sformatf("%s_mfhi", tag), bus_if.ex_to_mem_bus,
             exp_bus(PC0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd13, exp_hi));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  logic [158:0] sw_instr;
  logic [75:0]  sw_exp;

  initial begin
    stall_force         = 6'b000000;
    bus_if.id_to_ex_bus = '0;

    // Clock/reset block
    repeat (2) @(negedge clk);
    check_eq("reset_bus", bus_if.ex_to_mem_bus, 76'd0);
    check_eq("reset_stallreq", 76'(bus_if.stallreq_for_ex), 76'd0);
    check_eq("reset_sram_en", 76'(bus_if.data_sram_en), 76'd0);
    check_eq("reset_state", 76'(bus_if.div_state), 76'(ST_IDLE));
    rst = 1'b1;

    // ALU vectors (expected values computed by hand)
    alu_vec("addiu", PC0, {6'b001001, 5'd1, 5'd9, 16'hFFFF}, OP_ADD, S1_RS, S2_SX,
            32'd5, 32'd0, 32'h0000_0004);
    alu_vec("slt", PC0, {6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b101010}, OP_SLT, S1_RS, S2_RT,
            32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_vec("sltu", PC0, {6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b101011}, OP_SLTU, S1_RS, S2_RT,
            32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_vec("sra", PC0, {6'b0, 5'd0, 5'd2, 5'd3, 5'd4, 6'b000011}, OP_SRA, S1_SA, S2_RT,
            32'd0, 32'h8000_0000, 32'hF800_0000);
    alu_vec("srl", PC0, {6'b0, 5'd0, 5'd2, 5'd3, 5'd4, 6'b000010}, OP_SRL, S1_SA, S2_RT,
            32'd0, 32'h8000_0000, 32'h0800_0000);
    alu_vec("sll", PC0, {6'b0, 5'd0, 5'd2, 5'd3, 5'd8, 6'b000000}, OP_SLL, S1_SA, S2_RT,
            32'd0, 32'h0000_00AB, 32'h0000_AB00);
    alu_vec("lui", PC0, {6'b001111, 5'd0, 5'd8, 16'h1234}, OP_LUI, S1_NONE, S2_ZX,
            32'd0, 32'd0, 32'h1234_0000);
    alu_vec("subu_wrap", PC0, {6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100011}, OP_SUB, S1_RS, S2_RT,
            32'd3, 32'd5, 32'hFFFF_FFFE);
    alu_vec("nor", PC0, {6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100111}, OP_NOR, S1_RS, S2_RT,
            32'h0F0F_0000, 32'h00FF_00FF, 32'hF000_FF00);
    alu_vec("xor", PC0, {6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100110}, OP_XOR, S1_RS, S2_RT,
            32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    alu_vec("and", PC0, {6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100100}, OP_AND, S1_RS, S2_RT,
            32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    alu_vec("ori_zext", PC0, {6'b001101, 5'd1, 5'd7, 16'h8001}, OP_OR, S1_RS, S2_ZX,
            32'h0001_0000, 32'd0, 32'h0001_8001);
    alu_vec("pc_plus_8", 32'hBFC0_0010, {6'b000011, 5'd0, 5'd31, 16'h0000}, OP_ADD, S1_PC, S2_8,
            32'd0, 32'd0, 32'hBFC0_0018);

    // Store word
    sw_instr = mk(PC0, {6'b101011, 5'd1, 5'd2, 16'h0008}, OP_ADD, S1_RS, S2_SX, 1'b1, 4'hF,
                  1'b0, 5'd0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    sw_exp   = exp_bus(PC0, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_0108);
    issue(sw_instr);
    check_eq("sw_en", 76'(bus_if.data_sram_en), 76'd1);
    check_eq("sw_wen", 76'(bus_if.data_sram_wen), 76'hF);
    check_eq("sw_addr", 76'(bus_if.data_sram_addr), 76'h108);
    check_eq("sw_wdata", 76'(bus_if.data_sram_wdata), 76'hDEAD_BEEF);
    check_eq("sw_rf_we", 76'(bus_if.ex_to_mem_bus[37]), 76'd0);
    check_eq("sw_bus", bus_if.ex_to_mem_bus, sw_exp);

    // Hold (EX and MEM stopped) keeps the request; EX stopped alone bubbles.
    @(negedge clk);
    bus_if.id_to_ex_bus = mk_mf(1'b1, 5'd1);
    stall_force = 6'b001111;
    @(posedge clk);
    #1;
    check_eq("hold_bus", bus_if.ex_to_mem_bus, sw_exp);
    check_eq("hold_sram_addr", 76'(bus_if.data_sram_addr), 76'h108);
    stall_force = 6'b000111;
    @(posedge clk);
    #1;
    check_eq("bubble_bus", bus_if.ex_to_mem_bus, 76'd0);
    check_eq("bubble_sram_en", 76'(bus_if.data_sram_en), 76'd0);
    stall_force = 6'b000000;

    // Divider
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_div("divu_9_0", 1'b0, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 3);
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
    run_div("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 0);
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 0);

    // Reset in the middle of a divide
    issue(mk(PC0, {6'b0, 5'd4, 5'd5, 10'b0, 6'b011011}, OP_NONE, S1_NONE, 4'b0, 1'b0, 4'h0,
             1'b0, 5'd0, 1'b0, 32'd1000, 32'd3));
    repeat (5) @(posedge clk);
    #1;
    check_eq("busy_state", 76'(bus_if.div_state), 76'(ST_BUSY));
    check_eq("busy_stallreq", 76'(bus_if.stallreq_for_ex), 76'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst_busy_stallreq", 76'(bus_if.stallreq_for_ex), 76'd0);
    check_eq("rst_busy_state", 76'(bus_if.div_state), 76'(ST_IDLE));
    check_eq("rst_busy_bus", bus_if.ex_to_mem_bus, 76'd0);
    bus_if.id_to_ex_bus = mk_mf(1'b0, 5'd14);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_lo_zero", bus_if.ex_to_mem_bus, exp_bus(PC0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd14, 32'd0));
    issue(mk_mf(1'b1, 5'd15));
    check_eq("rst_hi_zero", bus_if.ex_to_mem_bus, exp_bus(PC0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd15, 32'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
